// File: rtl/rgb2ycbcr_mc_if.sv
// Pixel bus for rgb2ycbcr_mc: RGB plus syncs in, YCbCr plus delayed syncs and mode tag out.
interface rgb2ycbcr_mc_if #(
    parameter int DW = 8
);
    logic [1:0]      i_mode;
    logic [3*DW-1:0] i_rgb;
    logic            i_hsync;
    logic            i_vsync;
    logic            i_de;
    logic [3*DW-1:0] o_rgb;
    logic [3*DW-1:0] o_ycbcr;
    logic            o_hsync;
    logic            o_vsync;
    logic            o_de;
    logic [1:0]      o_mode;

    modport master (
        output i_mode, i_rgb, i_hsync, i_vsync, i_de,
        input  o_rgb, o_ycbcr, o_hsync, o_vsync, o_de, o_mode
    );

    modport slave (
        input  i_mode, i_rgb, i_hsync, i_vsync, i_de,
        output o_rgb, o_ycbcr, o_hsync, o_vsync, o_de, o_mode
    );
endinterface

// File: rtl/rgb2ycbcr_mc.sv
// Four-stage RGB to YCbCr converter with frame-synchronous mode switching and bypass.
// Optional studio-range clamp on converted modes: define RGB2YCBCR_STUDIO_CLAMP_EN.
module rgb2ycbcr_mc #(
    parameter int         DW        = 8,
    parameter logic [1:0] MODE_INIT = 2'd1
) (
    input logic           pixelclk,
    input logic           rst,
    rgb2ycbcr_mc_if.slave bus
);
    localparam int PW = DW + 10;
    localparam int AW = DW + 11;
    localparam int RW = DW + 3;
    localparam int XW = 3*DW + 3;

    localparam logic signed [8:0] C601S [9] = '{9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112,
                                                9'sd112, -9'sd94, -9'sd18};
    localparam logic signed [8:0] C709S [9] = '{9'sd47, 9'sd157, 9'sd16, -9'sd26, -9'sd86, 9'sd112,
                                                9'sd112, -9'sd102, -9'sd10};
    localparam logic signed [8:0] C601F [9] = '{9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128,
                                                9'sd128, -9'sd107, -9'sd21};
    localparam logic signed [AW-1:0] OFF_Y = AW'(16 << DW);
    localparam logic signed [AW-1:0] OFF_C = AW'(128 << DW);
    localparam logic signed [AW-1:0] RND   = AW'(128);
`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
    localparam logic [DW-1:0] CL_LO = DW'(16 << (DW-8));
    localparam logic [DW-1:0] CL_HY = DW'(235 << (DW-8));
    localparam logic [DW-1:0] CL_HC = DW'(240 << (DW-8));
`endif

    function automatic logic signed [8:0] coef(input logic [1:0] m, input int i);
        case (m)
            2'd0:    coef = C601S[i];
            2'd1:    coef = C709S[i];
            2'd2:    coef = C601F[i];
            default: coef = '0;
        endcase
    endfunction

    logic [1:0]            mode_q, mode_d;
    logic                  vs_prev_q, vs_prev_d;
    logic [XW-1:0]         dly_q [4];
    logic [XW-1:0]         dly_d [4];
    logic [1:0]            tag_q [4];
    logic [1:0]            tag_d [4];
    logic signed [PW-1:0]  prod_q [9];
    logic signed [PW-1:0]  prod_d [9];
    logic signed [AW-1:0]  sa_q [3];
    logic signed [AW-1:0]  sa_d [3];
    logic signed [AW-1:0]  sb_q [3];
    logic signed [AW-1:0]  sb_d [3];
    logic signed [AW-1:0]  sum3 [3];
    logic signed [RW-1:0]  sh_q [3];
    logic signed [RW-1:0]  sh_d [3];
    logic [3*DW-1:0]       ycc_q, ycc_d;
    logic [DW-1:0]         px [3];
    logic [DW-1:0]         ch;
    logic signed [AW-1:0]  off;

    always_comb begin
        mode_d    = mode_q;
        vs_prev_d = bus.i_vsync;
        if (bus.i_vsync && !vs_prev_q) mode_d = bus.i_mode;

        dly_d[0] = {bus.i_rgb, bus.i_hsync, bus.i_vsync, bus.i_de};
        tag_d[0] = mode_q;
        for (int k = 1; k < 4; k++) begin
            dly_d[k] = dly_q[k-1];
            tag_d[k] = tag_q[k-1];
        end

        px[0] = bus.i_rgb[3*DW-1:2*DW];
        px[1] = bus.i_rgb[2*DW-1:DW];
        px[2] = bus.i_rgb[DW-1:0];
        for (int i = 0; i < 9; i++)
            prod_d[i] = PW'(coef(mode_q, i)) * PW'($signed({1'b0, px[i % 3]}));

        off = '0;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) off = (tag_q[0] == 2'd2) ? '0 : OFF_Y;
            else        off = OFF_C;
            sa_d[c] = AW'(prod_q[3*c]) + AW'(prod_q[3*c+1]);
            sb_d[c] = AW'(prod_q[3*c+2]) + off + RND;
            sum3[c] = sa_q[c] + sb_q[c];
            sh_d[c] = RW'(sum3[c] >>> 8);
        end

        // Stage 4: saturate (and optionally clamp) converted modes, pass bypass through untouched.
        ycc_d = '0;
        ch    = '0;
        for (int c = 0; c < 3; c++) begin
            if (sh_q[c][RW-1])          ch = '0;
            else if (|sh_q[c][RW-2:DW]) ch = '1;
            else                        ch = sh_q[c][DW-1:0];
`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
            if (ch < CL_LO) ch = CL_LO;
            else if (c == 0 && ch > CL_HY) ch = CL_HY;
            else if (c != 0 && ch > CL_HC) ch = CL_HC;
`endif
            if (tag_q[2] == 2'd3) ch = dly_q[2][XW-1-c*DW -: DW];
            ycc_d[3*DW-1-c*DW -: DW] = ch;
        end
        if (!dly_q[2][0]) ycc_d = '0;
    end

    always_ff @(posedge pixelclk) begin
        if (rst) begin
            mode_q    <= MODE_INIT;
            vs_prev_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                dly_q[k] <= '0;
                tag_q[k] <= MODE_INIT;
            end
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
            for (int c = 0; c < 3; c++) begin
                sa_q[c] <= '0;
                sb_q[c] <= '0;
                sh_q[c] <= '0;
            end
            ycc_q <= '0;
        end else begin
            mode_q    <= mode_d;
            vs_prev_q <= vs_prev_d;
            for (int k = 0; k < 4; k++) begin
                dly_q[k] <= dly_d[k];
                tag_q[k] <= tag_d[k];
            end
            for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            for (int c = 0; c < 3; c++) begin
                sa_q[c] <= sa_d[c];
                sb_q[c] <= sb_d[c];
                sh_q[c] <= sh_d[c];
            end
            ycc_q <= ycc_d;
        end
    end

    assign bus.o_rgb   = dly_q[3][XW-1:3];
    assign bus.o_hsync = dly_q[3][2];
    assign bus.o_vsync = dly_q[3][1];
    assign bus.o_de    = dly_q[3][0];
    assign bus.o_ycbcr = ycc_q;
    assign bus.o_mode  = tag_q[3];
endmodule

// File: tb/tb_rgb2ycbcr_mc.sv
// Directed scoreboard bench for rgb2ycbcr_mc at DW=8, MODE_INIT=1.
module tb_rgb2ycbcr_mc;
    localparam int         DW = 8;
    localparam logic [1:0] MI = 2'd1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb2ycbcr_mc_if #(.DW(DW)) bus ();
    rgb2ycbcr_mc #(.DW(DW), .MODE_INIT(MI)) dut (.pixelclk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [23:0] ycc;
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [1:0]  mode;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] m_mode;
    logic       m_vprev;

    int coefs [3][9] = '{'{66, 129, 25, -38, -74, 112, 112, -94, -18},
                         '{47, 157, 16, -26, -86, 112, 112, -102, -10},
                         '{77, 150, 29, -43, -85, 128, 128, -107, -21}};

    function automatic logic [23:0] conv(input logic [1:0] m, input logic [23:0] rgb);
        int px[3];
        int acc;
        int v;
        logic [23:0] r;
        if (m == 2'd3) return rgb;
        px[0] = int'(rgb[23:16]);
        px[1] = int'(rgb[15:8]);
        px[2] = int'(rgb[7:0]);
        r = '0;
        for (int c = 0; c < 3; c++) begin
            acc = coefs[m][3*c]*px[0] + coefs[m][3*c+1]*px[1] + coefs[m][3*c+2]*px[2]
                  + ((c == 0) ? ((m == 2'd2) ? 0 : 16) : 128) * 256 + 128;
            v = acc >>> 8;
            if (v < 0)   v = 0;
            if (v > 255) v = 255;
`ifdef RGB2YCBCR_STUDIO_CLAMP_EN
            if (v < 16) v = 16;
            if (c == 0 && v > 235) v = 235;
            if (c != 0 && v > 240) v = 240;
`endif
            r[23-8*c -: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] m, input logic [23:0] rgb, input logic hs,
                       input logic vs, input logic de);
        exp_t e;
        @(negedge clk);
        rst         = 1'b0;
        bus.i_mode  = m;
        bus.i_rgb   = rgb;
        bus.i_hsync = hs;
        bus.i_vsync = vs;
        bus.i_de    = de;
        e.ycc  = de ? conv(m_mode, rgb) : 24'h0;
        e.rgb  = rgb;
        e.hs   = hs;
        e.vs   = vs;
        e.de   = de;
        e.mode = m_mode;
        q.push_back(e);
        if (vs && !m_vprev) m_mode = m;
        m_vprev = vs;
        @(posedge clk);
        #1;
        if (q.size() >= 4) begin
            e = q.pop_front();
            chk("ycbcr", 32'(bus.o_ycbcr), 32'(e.ycc));
            chk("rgb",   32'(bus.o_rgb),   32'(e.rgb));
            chk("syncs", 32'({bus.o_hsync, bus.o_vsync, bus.o_de}), 32'({e.hs, e.vs, e.de}));
            chk("mode",  32'(bus.o_mode),  32'(e.mode));
        end
    endtask

    task automatic do_reset();
        exp_t z;
        @(negedge clk);
        rst         = 1'b1;
        bus.i_mode  = 2'd2;
        bus.i_rgb   = 24'hA5C3E1;
        bus.i_hsync = 1'b1;
        bus.i_vsync = 1'b0;
        bus.i_de    = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ycbcr", 32'(bus.o_ycbcr), 32'h0);
        chk("rst_rgb",   32'(bus.o_rgb),   32'h0);
        chk("rst_syncs", 32'({bus.o_hsync, bus.o_vsync, bus.o_de}), 32'h0);
        chk("rst_mode",  32'(bus.o_mode),  32'(MI));
        q.delete();
        z = '0;
        z.mode = MI;
        for (int i = 0; i < 3; i++) q.push_back(z);
        m_mode  = MI;
        m_vprev = 1'b0;
    endtask

    initial begin
        bus.i_mode  = 2'd0;
        bus.i_rgb   = '0;
        bus.i_hsync = 1'b0;
        bus.i_vsync = 1'b0;
        bus.i_de    = 1'b0;
        m_mode      = MI;
        m_vprev     = 1'b0;
        do_reset();

        // mode requests mid-frame are ignored: still BT.709 studio
        cyc(2'd3, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        cyc(2'd3, 24'h123456, 1'b0, 1'b0, 1'b1);
        cyc(2'd3, 24'h804020, 1'b1, 1'b0, 1'b1);

        // switch to 601 studio; a change while vsync is held high is ignored
        cyc(2'd0, 24'h000000, 1'b0, 1'b1, 1'b0);
        cyc(2'd2, 24'h000000, 1'b0, 1'b1, 1'b0);
        cyc(2'd2, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        cyc(2'd2, 24'h000000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(2'd2, 24'($urandom), 1'b0, 1'b0, 1'b1);

        // 601 full range, including Cr saturation
        cyc(2'd2, 24'h000000, 1'b0, 1'b1, 1'b0);
        cyc(2'd2, 24'hFF0000, 1'b0, 1'b0, 1'b1);
        cyc(2'd2, 24'h000000, 1'b0, 1'b0, 1'b1);
        cyc(2'd2, 24'h00FF00, 1'b1, 1'b0, 1'b1);
        cyc(2'd2, 24'h0000FF, 1'b0, 1'b0, 1'b1);
        cyc(2'd2, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) cyc(2'd2, 24'h3C7FA0, i[1], 1'b0, i[0]);

        // bypass
        cyc(2'd3, 24'h000000, 1'b0, 1'b1, 1'b0);
        cyc(2'd3, 24'h123456, 1'b0, 1'b0, 1'b1);
        cyc(2'd3, 24'hABCDEF, 1'b0, 1'b0, 1'b0);
        cyc(2'd3, 24'hFF0000, 1'b0, 1'b0, 1'b1);

        cyc(2'd1, 24'h000000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(2'd1, 24'($urandom), 1'b0, 1'b0, 1'b1);

        // reset with pixels in flight, then vsync high on the first edge counts as a rise
        do_reset();
        cyc(2'd0, 24'h102030, 1'b0, 1'b1, 1'b1);
        cyc(2'd0, 24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        cyc(2'd0, 24'h000000, 1'b0, 1'b0, 1'b1);
        cyc(2'd0, 24'h55AA33, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(2'd0, 24'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
